// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default frame geometry
// and the 3-sample majority vote used to recover each bit.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Vote window centred on the middle of a bit, for the default oversample rate.
  localparam int VOTE_FIRST_DEF = OVERSAMPLE_DEF / 2 - 1;
  localparam int VOTE_EVAL_DEF  = OVERSAMPLE_DEF / 2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_core_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is a
// parameter so idle-high lines do not glitch low coming out of reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, giving a true two-stage delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver: start-bit qualification, 3-sample majority
// voting, framing-error and overrun reporting, one-entry valid/ready output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_bus,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int TW         = $clog2(OVERSAMPLE);
  localparam int BW         = $clog2(DATA_BITS) + 1;
  localparam int VOTE_FIRST = OVERSAMPLE / 2 - 1;
  localparam int VOTE_EVAL  = OVERSAMPLE / 2 + 1;

  logic rx_s;

  sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [2:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] bus_q, bus_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic       deliver;
  logic       in_vote_win;
  logic       at_eval;
  logic       at_wrap;
  logic [2:0] vote_now;
  logic       bit_val;

  assign in_vote_win = (tick_q >= TW'(VOTE_FIRST)) && (tick_q <= TW'(VOTE_EVAL));
  assign at_eval     = (tick_q == TW'(VOTE_EVAL));
  assign at_wrap     = (tick_q == TW'(OVERSAMPLE - 1));
  // The third vote sample is the current rx_s, so the decision is made on the
  // same tick that shifts it in.
  assign vote_now    = {vote_q[1:0], rx_s};
  assign bit_val     = majority3(vote_now);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    vote_d      = vote_q;
    shreg_d     = shreg_q;
    brk_d       = brk_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    if (sample) begin
      tick_d = at_wrap ? '0 : tick_q + 1'b1;
      if (state_q != IDLE && in_vote_win) begin
        vote_d = vote_now;
      end

      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!rx_s) begin
            // The detecting tick is tick 0 of the start bit.
            state_d = START;
            tick_d  = TW'(1);
          end
        end
        START: begin
          if (at_eval && bit_val) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (at_wrap) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (at_eval) begin
            shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          end
          if (at_wrap) begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (brk_q) begin
            // Line held low after a bad stop bit: wait for it to return idle.
            if (rx_s) begin
              state_d = IDLE;
              tick_d  = '0;
              brk_d   = 1'b0;
            end
          end else if (at_eval) begin
            if (bit_val) begin
              deliver = 1'b1;
              state_d = IDLE;
              tick_d  = '0;
            end else begin
              frame_err_d = 1'b1;
              brk_d       = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus_d     = bus_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!valid_q || i_ready) begin
        bus_d   = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign busy_d = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      vote_q      <= 3'b111;
      shreg_q     <= '0;
      brk_q       <= 1'b0;
      bus_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      vote_q      <= vote_d;
      shreg_q     <= shreg_d;
      brk_q       <= brk_d;
      bus_q       <= bus_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_bus       = bus_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: drives 8N1 frames at 16 ticks per bit with
// one sample tick every 4 clocks and checks deliveries, pulses and reset.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample;
  logic       rx;
  logic [7:0] o_bus;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Monitor accumulators (written only by the monitor; tests take deltas).
  int         n_valid_cyc = 0;
  int         n_fe        = 0;
  int         n_ov        = 0;
  int         n_busy_cyc  = 0;
  logic [7:0] got[$];

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .rx          (rx),
    .o_bus       (o_bus),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    sample = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (o_valid && i_ready) got.push_back(o_bus);
      if (o_valid)     n_valid_cyc = n_valid_cyc + 1;
      if (o_frame_err) n_fe        = n_fe + 1;
      if (o_overrun)   n_ov        = n_ov + 1;
      if (o_busy)      n_busy_cyc  = n_busy_cyc + 1;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sample !== 1'b1);
    end
    #1;
  endtask

  // Drives a full frame; glitch_bit >= 0 inverts that bit for its middle vote tick only.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int glitch_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == glitch_bit) begin
        wait_ticks(8);
        rx = ~b[i];
        wait_ticks(1);
        rx = b[i];
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    rx = stop_val;
    wait_ticks(16);
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_cnt++; if (o_bus !== 8'h00) $display("FAIL reset_bus: got %h want 00", o_bus); else pass_cnt++;
    check_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
    check_cnt++; if (o_frame_err !== 1'b0) $display("FAIL reset_fe: got %b want 0", o_frame_err); else pass_cnt++;
    check_cnt++; if (o_overrun !== 1'b0) $display("FAIL reset_ov: got %b want 0", o_overrun); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    int g0, v0, f0, o0;
    g0 = got.size(); v0 = n_valid_cyc; f0 = n_fe; o0 = n_ov;
    i_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(2);
    check_cnt++; if (got.size() - g0 !== 1) $display("FAIL basic_count: got %0d want 1", got.size() - g0); else pass_cnt++;
    check_cnt++; if (got.size() > g0 && got[got.size()-1] !== 8'hA5) $display("FAIL basic_data: got %h want a5", got[got.size()-1]); else pass_cnt++;
    check_cnt++; if (n_valid_cyc - v0 !== 1) $display("FAIL basic_valid_len: got %0d want 1", n_valid_cyc - v0); else pass_cnt++;
    check_cnt++; if ((n_fe - f0) + (n_ov - o0) !== 0) $display("FAIL basic_pulses: got %0d want 0", (n_fe - f0) + (n_ov - o0)); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_glitch_start();
    int v0, f0, b0;
    v0 = n_valid_cyc; f0 = n_fe; b0 = n_busy_cyc;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check_cnt++; if (n_busy_cyc - b0 <= 0) $display("FAIL glitch_busy_seen: got %0d cycles want >0", n_busy_cyc - b0); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", o_busy); else pass_cnt++;
    check_cnt++; if (n_valid_cyc - v0 !== 0) $display("FAIL glitch_valid: got %0d want 0", n_valid_cyc - v0); else pass_cnt++;
    check_cnt++; if (n_fe - f0 !== 0) $display("FAIL glitch_fe: got %0d want 0", n_fe - f0); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int g0, v0, f0;
    g0 = got.size(); v0 = n_valid_cyc; f0 = n_fe;
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(16);
    check_cnt++; if (o_busy !== 1'b1) $display("FAIL ferr_hold_busy: got %b want 1", o_busy); else pass_cnt++;
    check_cnt++; if (n_fe - f0 !== 1) $display("FAIL ferr_pulse: got %0d want 1", n_fe - f0); else pass_cnt++;
    check_cnt++; if (n_valid_cyc - v0 !== 0) $display("FAIL ferr_valid: got %0d want 0", n_valid_cyc - v0); else pass_cnt++;
    rx = 1'b1;
    wait_ticks(4);
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL ferr_idle: got %b want 0", o_busy); else pass_cnt++;
    send_frame(8'h81, 1'b1, -1);
    wait_ticks(2);
    check_cnt++; if (got.size() - g0 !== 1) $display("FAIL ferr_next_count: got %0d want 1", got.size() - g0); else pass_cnt++;
    check_cnt++; if (got.size() > g0 && got[got.size()-1] !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", got[got.size()-1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int g0, f0, o0;
    g0 = got.size(); f0 = n_fe; o0 = n_ov;
    i_ready = 1'b0;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(2);
    @(negedge clk);
    check_cnt++; if (o_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", o_valid); else pass_cnt++;
    check_cnt++; if (o_bus !== 8'h00) $display("FAIL ovr_bus_kept: got %h want 00", o_bus); else pass_cnt++;
    check_cnt++; if (n_ov - o0 !== 1) $display("FAIL ovr_pulse: got %0d want 1", n_ov - o0); else pass_cnt++;
    check_cnt++; if (n_fe - f0 !== 0) $display("FAIL ovr_fe: got %0d want 0", n_fe - f0); else pass_cnt++;
    @(posedge clk); #1 i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cnt++; if (o_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", o_valid); else pass_cnt++;
    check_cnt++; if (got.size() - g0 !== 1 || got[got.size()-1] !== 8'h00) $display("FAIL ovr_xfer: got %0d xfers want 1 of 00", got.size() - g0); else pass_cnt++;
  endtask

  task automatic test_vote_glitch();
    int g0;
    g0 = got.size();
    i_ready = 1'b1;
    wait_ticks(1);
    send_frame(8'h55, 1'b1, 3);
    wait_ticks(2);
    check_cnt++; if (got.size() - g0 !== 1) $display("FAIL vote_count: got %0d want 1", got.size() - g0); else pass_cnt++;
    check_cnt++; if (got.size() > g0 && got[got.size()-1] !== 8'h55) $display("FAIL vote_data: got %h want 55", got[got.size()-1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int g0, f0, o0;
    logic [7:0] b;
    b = 8'h5A;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 2; i++) begin
      rx = b[i];
      wait_ticks(16);
    end
    rx = b[2];
    wait_ticks(4);
    @(negedge clk);
    check_cnt++; if (o_busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", o_busy); else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++; if (o_bus !== 8'h00) $display("FAIL rmid_bus: got %h want 00", o_bus); else pass_cnt++;
    check_cnt++; if (o_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", o_valid); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", o_busy); else pass_cnt++;
    check_cnt++; if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) $display("FAIL rmid_pulses: got %b%b want 00", o_frame_err, o_overrun); else pass_cnt++;
    rx = b[3];
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(4);
    @(posedge clk); #1 rst = 1'b1;
    g0 = got.size(); f0 = n_fe; o0 = n_ov;
    wait_ticks(20);
    check_cnt++; if (got.size() - g0 !== 0 || (n_fe - f0) + (n_ov - o0) !== 0) $display("FAIL rmid_quiet: got %0d events want 0", got.size() - g0 + n_fe - f0 + n_ov - o0); else pass_cnt++;
    send_frame(8'hC3, 1'b1, -1);
    wait_ticks(2);
    check_cnt++; if (got.size() - g0 !== 1) $display("FAIL rmid_count: got %0d want 1", got.size() - g0); else pass_cnt++;
    check_cnt++; if (got.size() > g0 && got[got.size()-1] !== 8'hC3) $display("FAIL rmid_data: got %h want c3", got[got.size()-1]); else pass_cnt++;
  endtask

  initial begin
    rst     = 1'b0;
    rx      = 1'b1;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_glitch_start();
    test_frame_err();
    test_back_to_back();
    test_vote_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
